// File: rtl/iu_exec_wb.sv
// Execute-to-writeback stage of the SPARC integer unit: one-entry result buffer,
// architectural ICC register with WRPSR path, adder carry feedback and Bicc evaluation.
module iu_exec_wb (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_op,
  input  logic [31:0] in_result,
  input  logic [3:0]  in_flags,
  input  logic [4:0]  in_rd,
  input  logic        in_we,
  input  logic        wrpsr_en,
  input  logic [3:0]  wrpsr_icc,
  input  logic        bicc_valid,
  input  logic [3:0]  bicc_cond,
  input  logic        bicc_annul,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_we,
  output logic [3:0]  icc,
  output logic        carry_out,
  output logic        br_valid,
  output logic        br_taken,
  output logic        br_annul,
  output logic        illegal_op
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // Ready never looks at valid, and a valid producer holds its payload until accepted.

  logic        r_out_valid;
  logic [31:0] r_out_result;
  logic [4:0]  r_out_rd;
  logic        r_out_we;
  logic [3:0]  r_icc;
  logic        r_br_valid;
  logic        r_br_taken;
  logic        r_br_annul;
  logic        r_illegal;

  logic       w_accept;
  logic       w_legal;
  logic       w_cc_upd;
  logic [3:0] w_icc_nx;
  logic       w_n;
  logic       w_z;
  logic       w_v;
  logic       w_c;
  logic       w_taken;
  logic       w_annul;

  // Reset discards the buffer, so the stage is always ready while rst is high.
  assign in_ready = rst | ~r_out_valid | out_ready;
  assign w_accept = in_valid & in_ready;

  // Legal encodings are exactly bit5=0 and bits[1:0]=0; bit4 marks the cc variant.
  assign w_legal  = ~in_op[5] & (in_op[1:0] == 2'b00);
  assign w_cc_upd = w_accept & w_legal & in_op[4];

  always_comb begin
    w_icc_nx = r_icc;
    if (w_cc_upd) begin
      w_icc_nx = in_flags;
    end else if (wrpsr_en) begin
      w_icc_nx = wrpsr_icc;
    end
  end

  assign w_n = w_icc_nx[3];
  assign w_z = w_icc_nx[2];
  assign w_v = w_icc_nx[1];
  assign w_c = w_icc_nx[0];

  // Branches see the ICC value being written this cycle (bypass).
  always_comb begin
    w_taken = 1'b0;
    case (bicc_cond)
      4'h0: w_taken = 1'b0;
      4'h1: w_taken = w_z;
      4'h2: w_taken = w_z | (w_n ^ w_v);
      4'h3: w_taken = w_n ^ w_v;
      4'h4: w_taken = w_c | w_z;
      4'h5: w_taken = w_c;
      4'h6: w_taken = w_n;
      4'h7: w_taken = w_v;
      4'h8: w_taken = 1'b1;
      4'h9: w_taken = ~w_z;
      4'hA: w_taken = ~(w_z | (w_n ^ w_v));
      4'hB: w_taken = ~(w_n ^ w_v);
      4'hC: w_taken = ~(w_c | w_z);
      4'hD: w_taken = ~w_c;
      4'hE: w_taken = ~w_n;
      4'hF: w_taken = ~w_v;
      default: w_taken = 1'b0;
    endcase
  end

  // BA,a annuls the delay slot even though it is taken.
  assign w_annul = bicc_annul & (~w_taken | (bicc_cond == 4'h8));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_result <= 32'h0;
      r_out_rd     <= 5'h0;
      r_out_we     <= 1'b0;
    end else if (w_accept) begin
      r_out_valid  <= 1'b1;
      r_out_result <= in_result;
      r_out_rd     <= in_rd;
      r_out_we     <= in_we;
    end else if (out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_icc      <= 4'h0;
      r_br_valid <= 1'b0;
      r_br_taken <= 1'b0;
      r_br_annul <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      r_icc      <= w_icc_nx;
      r_br_valid <= bicc_valid;
      r_br_taken <= bicc_valid & w_taken;
      r_br_annul <= bicc_valid & w_annul;
      r_illegal  <= w_accept & ~w_legal;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_rd     = r_out_rd;
  assign out_we     = r_out_valid & r_out_we;
  assign icc        = r_icc;
  assign carry_out  = r_icc[0];
  assign br_valid   = r_br_valid;
  assign br_taken   = r_br_taken;
  assign br_annul   = r_br_annul;
  assign illegal_op = r_illegal;

endmodule

// File: tb/tb_iu_exec_wb.sv
// Self-checking bench for iu_exec_wb: directed ICC/Bicc cases, random branch
// conditions, back-pressure streaming through a scoreboard, illegal op and reset.
module tb_iu_exec_wb;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_op;
  logic [31:0] in_result;
  logic [3:0]  in_flags;
  logic [4:0]  in_rd;
  logic        in_we;
  logic        wrpsr_en;
  logic [3:0]  wrpsr_icc;
  logic        bicc_valid;
  logic [3:0]  bicc_cond;
  logic        bicc_annul;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_we;
  logic [3:0]  icc;
  logic        carry_out;
  logic        br_valid;
  logic        br_taken;
  logic        br_annul;
  logic        illegal_op;

  int n_tests = 0;
  int n_fail  = 0;
  int n_push  = 0;
  int n_pop   = 0;
  logic [37:0] exp_q[$];
  logic [3:0]  exp_icc;

  iu_exec_wb dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_result(in_result),
    .in_flags(in_flags), .in_rd(in_rd), .in_we(in_we),
    .wrpsr_en(wrpsr_en), .wrpsr_icc(wrpsr_icc),
    .bicc_valid(bicc_valid), .bicc_cond(bicc_cond), .bicc_annul(bicc_annul),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_we(out_we), .icc(icc), .carry_out(carry_out),
    .br_valid(br_valid), .br_taken(br_taken), .br_annul(br_annul),
    .illegal_op(illegal_op)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic model_taken(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, v, c, base;
    n = f[3]; z = f[2]; v = f[1]; c = f[0];
    case (cond[2:0])
      3'd0: base = 1'b0;
      3'd1: base = z;
      3'd2: base = z | (n ^ v);
      3'd3: base = n ^ v;
      3'd4: base = c | z;
      3'd5: base = c;
      3'd6: base = n;
      default: base = v;
    endcase
    return cond[3] ? ~base : base;
  endfunction

  // driver: present one entry, wait for ready, record expectation, cross the edge
  task automatic send(input logic [5:0] op, input logic [31:0] res, input logic [4:0] rd,
                      input logic we, input logic [3:0] fl);
    int budget;
    in_op = op; in_result = res; in_rd = rd; in_we = we; in_flags = fl;
    in_valid = 1'b1;
    budget = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      budget++;
      if (budget > 50) begin
        check("send_timeout", 1, 0);
        in_valid = 1'b0;
        return;
      end
    end
    exp_q.push_back({we, rd, res});
    n_push++;
    tick();
    in_valid = 1'b0;
  endtask

  // scoreboard: pop on every writeback handshake
  always @(negedge clk) begin
    if (!rst) begin
      if (!out_valid) check("we_gated", out_we, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected", 1, 0);
        end else begin
          logic [37:0] e;
          e = exp_q.pop_front();
          n_pop++;
          check("sb_result", out_result, e[31:0]);
          check("sb_rd", out_rd, e[36:32]);
          check("sb_we", out_we, e[37]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 0; in_op = 0; in_result = 0; in_flags = 0; in_rd = 0; in_we = 0;
    wrpsr_en = 0; wrpsr_icc = 0; bicc_valid = 0; bicc_cond = 0; bicc_annul = 0; out_ready = 1;
    tick();
    check("rst_in_ready", in_ready, 1);
    tick();
    rst = 1'b0;
    tick();

    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_rd", out_rd, 0);
    check("rst_out_we", out_we, 0);
    check("rst_icc", icc, 0);
    check("rst_carry", carry_out, 0);
    check("rst_br", {br_valid, br_taken, br_annul, illegal_op}, 0);
    check("idle_in_ready", in_ready, 1);

    // plain ADD
    send(6'b000000, 32'h5, 5'd3, 1'b1, 4'b1111);
    check("add_valid", out_valid, 1);
    check("add_result", out_result, 32'h5);
    check("add_rd", out_rd, 3);
    check("add_we", out_we, 1);
    check("add_icc", icc, 0);

    // ADDcc then ADDX, then SUB leaves ICC alone
    send(6'b010000, 32'h10, 5'd4, 1'b1, 4'b0001);
    check("addcc_icc", icc, 4'b0001);
    check("addcc_carry", carry_out, 1);
    send(6'b001000, 32'h11, 5'd5, 1'b1, 4'b0000);
    check("addx_carry", carry_out, 1);
    send(6'b000100, 32'h12, 5'd6, 1'b0, 4'b1000);
    check("sub_icc", icc, 4'b0001);

    // SUBcc beats WRPSR; BE sees the bypassed ICC
    wrpsr_en = 1; wrpsr_icc = 4'b1000;
    bicc_valid = 1; bicc_cond = 4'h1; bicc_annul = 1;
    send(6'b010100, 32'h13, 5'd7, 1'b1, 4'b0100);
    wrpsr_en = 0; bicc_valid = 0;
    check("subcc_wins_icc", icc, 4'b0100);
    check("be_valid", br_valid, 1);
    check("be_taken", br_taken, 1);
    check("be_annul", br_annul, 0);
    tick();
    check("br_pulse", {br_valid, br_taken, br_annul}, 0);

    // WRPSR 1000 with BL bypassed in same cycle, then BGE, BA
    wrpsr_en = 1; wrpsr_icc = 4'b1000;
    bicc_valid = 1; bicc_cond = 4'h3; bicc_annul = 1;
    tick();
    wrpsr_en = 0;
    check("wrpsr_icc", icc, 4'b1000);
    check("bl_taken", br_taken, 1);
    check("bl_annul", br_annul, 0);
    bicc_cond = 4'hB;
    tick();
    check("bge_taken", br_taken, 0);
    check("bge_annul", br_annul, 1);
    bicc_cond = 4'h8;
    tick();
    check("ba_taken", br_taken, 1);
    check("ba_annul", br_annul, 1);
    bicc_cond = 4'h0;
    tick();
    check("bn_taken", br_taken, 0);
    check("bn_annul", br_annul, 1);

    // random conditions against random WRPSR values
    for (int i = 0; i < 24; i++) begin
      logic [3:0] w, c;
      logic a, t;
      w = 4'($urandom_range(0, 15));
      c = 4'($urandom_range(0, 15));
      a = 1'($urandom_range(0, 1));
      wrpsr_en = 1; wrpsr_icc = w; bicc_cond = c; bicc_annul = a;
      t = model_taken(c, w);
      tick();
      check("rnd_icc", icc, w);
      check("rnd_valid", br_valid, 1);
      check("rnd_taken", br_taken, t);
      check("rnd_annul", br_annul, a & (~t | (c == 4'h8)));
      exp_icc = w;
    end
    wrpsr_en = 0; bicc_valid = 0; bicc_annul = 0;
    tick();
    check("rnd_br_idle", br_valid, 0);

    // back-pressure: hold A, stream B..E behind it
    out_ready = 0;
    send(6'b000000, 32'hA000_000A, 5'd10, 1'b1, 4'b0000);
    fork
      begin
        for (int k = 0; k < 4; k++)
          send(6'b000000, 32'hB000_0000 + 32'(k), 5'(11 + k), 1'(k[0]), 4'b0000);
      end
      begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("bp_in_ready", in_ready, 0);
          check("bp_valid", out_valid, 1);
          check("bp_result", out_result, 32'hA000_000A);
          check("bp_rd", out_rd, 10);
        end
        tick();
        out_ready = 1;
      end
    join
    repeat (3) tick();
    check("bp_drained", exp_q.size(), 0);
    check("bp_count", n_pop, n_push);
    check("bp_icc", icc, exp_icc);

    // illegal op passes through without touching ICC
    send(6'b111111, 32'hDEAD_BEEF, 5'd31, 1'b1, 4'b1111);
    check("ill_pulse", illegal_op, 1);
    check("ill_icc", icc, exp_icc);
    check("ill_result", out_result, 32'hDEAD_BEEF);
    tick();
    check("ill_clear", illegal_op, 0);

    // reset with an in-flight entry
    out_ready = 0;
    send(6'b010000, 32'h77, 5'd2, 1'b1, 4'b0110);
    check("pre_rst_icc", icc, 4'b0110);
    check("pre_rst_valid", out_valid, 1);
    rst = 1;
    @(negedge clk);
    check("rst_mid_in_ready", in_ready, 1);
    tick();
    exp_q.delete();
    rst = 0;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_icc", icc, 0);
    check("rst_mid_carry", carry_out, 0);
    check("rst_mid_in_ready2", in_ready, 1);
    out_ready = 1;
    repeat (2) tick();
    check("end_q_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/iu_exec_wb.md
# iu_exec_wb

Execute-to-writeback stage of the SPARC integer unit, directly downstream of the integer adder. Registers the adder's 32-bit result and n/z/v/c flags into a one-entry pipeline buffer with a valid/ready handshake. Owns the architectural ICC register: updates it on `cc` ops, feeds carry back to the adder for ADDX/SUBX, and evaluates Bicc branch conditions with same-cycle ICC bypass.

## Interface
- No parameters. Widths are fixed by the SPARC V8 integer unit.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: adder output is presented this cycle.
- `in_ready` out 1: stage can accept this cycle.
- `in_op` in 6: adder op code, same encoding as the adder.
- `in_result` in 32: adder result.
- `in_flags` in 4: adder flags, [3]=n, [2]=z, [1]=v, [0]=c.
- `in_rd` in 5: destination register index.
- `in_we` in 1: instruction writes `rd`.
- `wrpsr_en` in 1: direct ICC write (WRPSR path).
- `wrpsr_icc` in 4: ICC value for WRPSR.
- `bicc_valid` in 1: evaluate a branch this cycle.
- `bicc_cond` in 4: Bicc cond field.
- `bicc_annul` in 1: branch `a` bit.
- `out_valid` out 1: writeback entry valid.
- `out_ready` in 1: register file accepts the entry.
- `out_result` out 32: registered result.
- `out_rd` out 5: registered destination index.
- `out_we` out 1: registered write enable, forced 0 when `out_valid`=0.
- `icc` out 4: architectural ICC, same bit order as `in_flags`.
- `carry_out` out 1: equals `icc[0]`; drives the adder carry input.
- `br_valid` out 1: branch decision valid, one-cycle pulse.
- `br_taken` out 1: branch taken.
- `br_annul` out 1: delay slot annulled.
- `illegal_op` out 1: one-cycle pulse on an accepted unknown op.

## Operation
- Legal ops are 000000, 010000, 001000, 011000, 000100, 010100, 001100 and 011100. An op is a `cc` op when `in_op[4]`=1.
- Accept condition: `in_valid & in_ready`.
- `in_ready` = `!out_valid | out_ready`. It is combinational and has no dependency on `in_valid`.
- On accept:
  - `out_result`, `out_rd` and `out_we` load from the inputs, and `out_valid` goes to 1.
  - On a `cc` op, `icc` loads `in_flags`.
- When `out_valid & out_ready` and there is no accept, `out_valid` clears to 0.
- Accept and drain in the same cycle: the buffer reloads and `out_valid` stays 1.
- Unknown op accepted:
  - Passes through to writeback.
  - No ICC update.
  - `illegal_op` pulses 1 for one cycle.
- WRPSR:
  - When `wrpsr_en`=1, `icc` loads `wrpsr_icc`.
  - An accepted `cc` op in the same cycle wins, and WRPSR is dropped.
- Next ICC (`icc_nx`): the value `icc` will take at the next edge, using the priority above.
- Bicc evaluates against `icc_nx` (bypass). Conditions by `bicc_cond`:
  - 0 N: never; 8 A: always.
  - 1 E: z; 9 NE: ~z.
  - 2 LE: z|(n^v); A G: ~(z|(n^v)).
  - 3 L: n^v; B GE: ~(n^v).
  - 4 LEU: c|z; C GU: ~(c|z).
  - 5 CS: c; D CC: ~c.
  - 6 NEG: n; E POS: ~n.
  - 7 VS: v; F VC: ~v.
- Branch decision:
  - `br_annul` = `bicc_annul & (!taken | bicc_cond==8)`.
  - `br_valid`, `br_taken` and `br_annul` register on the edge after `bicc_valid`=1.
  - `br_valid` is 0 in every cycle with no request. `br_taken` and `br_annul` are 0 whenever `br_valid`=0.
- Back-pressure: while `out_valid=1 & out_ready=0`, all `out_*` values hold stable.

## Timing
- Reset values: `out_valid`=0, `out_result`=0, `out_rd`=0, `out_we`=0, `icc`=0, `carry_out`=0, `br_valid`=0, `br_taken`=0, `br_annul`=0, `illegal_op`=0.
- `rst` overrides accept, WRPSR and Bicc in the same cycle; an in-flight entry is discarded. `in_ready`=1 during and after reset.
- Latency:
  - Input to `out_*`: 1 cycle.
  - `cc` flags to `icc`/`carry_out`: 1 cycle.
  - `bicc_valid` to `br_*`: 1 cycle.
- Throughput: 1 entry per cycle while `out_ready`=1.
- `carry_out` is registered, so back-to-back ADDcc then ADDX sees the ADDcc carry.

## Test plan
- Reset, then idle: all outputs 0 and `in_ready`=1. Then accept ADD, result 0x0000_0005, rd=3, we=1 → next cycle `out_valid`=1, `out_result`=5, `out_rd`=3, `out_we`=1, `icc` unchanged at 0.
- ADDcc with flags 4'b0001 accepted, then ADDX → `carry_out`=1 from the cycle after the ADDcc. A following SUB (non-cc) with flags 4'b1000 leaves `icc`=4'b0001.
- Same cycle: accepted SUBcc with flags 4'b0100, WRPSR 4'b1000, `bicc_valid` with cond=1 (BE) and a=1 → `icc`=4'b0100; next cycle `br_valid`=1, `br_taken`=1, `br_annul`=0.
- `icc`=4'b1000 with bicc cond=3 (BL), a=1 → taken=1, annul=0. cond=B (BGE), a=1 → taken=0, annul=1. cond=8 (BA), a=1 → taken=1, annul=1.
- `out_ready`=0 for 3 cycles with a continuous valid stream → `in_ready`=0 and `out_*` stable. On release, one entry drains per cycle in order with no loss or duplication.
- Accept op 6'b111111 → `illegal_op` pulses 1 for one cycle, `icc` unchanged. Assert `rst` mid-stream with `out_valid`=1 → next cycle `out_valid`=0 and `icc`=0.
